// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU bus between the register-read stage, alu_issue_ctrl and the external ALU.
// master = alu_issue_ctrl side, slave = surrounding pipeline/ALU side.
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int IMM_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_opcode;
   logic [5:0]       in_funct;
   logic [WIDTH-1:0] in_rs;
   logic [WIDTH-1:0] in_rt;
   logic [IMM_W-1:0] in_imm;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_z;
   logic             alu_ex;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_taken;
   logic             res_err;

   modport master (
      input  in_valid, in_opcode, in_funct, in_rs, in_rt, in_imm,
      output in_ready,
      output alu_a, alu_b, alu_op,
      input  alu_z, alu_ex,
      output res_valid, res_data, res_taken, res_err,
      input  res_ready
   );

   modport slave (
      output in_valid, in_opcode, in_funct, in_rs, in_rt, in_imm,
      input  in_ready,
      input  alu_a, alu_b, alu_op,
      output alu_z, alu_ex,
      input  res_valid, res_data, res_taken, res_err,
      output res_ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: latches one decoded instruction, drives the external ALU with registered
// operands, captures its result/zero flag and returns result plus branch decision over valid/ready.
module alu_issue_ctrl #(
   parameter int               WIDTH       = 32,
   parameter int               IMM_W       = 16,
   parameter logic [WIDTH-1:0] ILLEGAL_VAL = {WIDTH{1'b0}}
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_issue_ctrl_if.master bus
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam int DEC_W = WIDTH + 4;

   logic [1:0]       state_r;
   logic             in_ready_r;
   logic [5:0]       opcode_r;
   logic [5:0]       funct_r;
   logic [WIDTH-1:0] rs_r;
   logic [WIDTH-1:0] rt_r;
   logic [IMM_W-1:0] imm_r;
   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;
   logic [2:0]       alu_op_r;
   logic             res_valid_r;
   logic [WIDTH-1:0] res_data_r;
   logic             res_taken_r;
   logic             res_err_r;

   logic [DEC_W-1:0] dec_s;
   logic             dec_legal_s;
   logic [2:0]       dec_op_s;
   logic [WIDTH-1:0] dec_b_s;

   // Packs {legal, alu_op, operand b}; unknown opcode/funct combinations come back illegal.
   function automatic logic [DEC_W-1:0] decode_f(
      input logic [5:0]       opc,
      input logic [5:0]       fn,
      input logic [WIDTH-1:0] rt,
      input logic [IMM_W-1:0] imm
   );
      logic [WIDTH-1:0] sext_v;
      logic [WIDTH-1:0] zext_v;
      logic [DEC_W-1:0] res_v;
      sext_v = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
      zext_v = {{(WIDTH-IMM_W){1'b0}}, imm};
      res_v  = {1'b0, OP_AND, {WIDTH{1'b0}}};
      case (opc)
         6'h00: begin
            case (fn)
               6'h20:   res_v = {1'b1, OP_ADD, rt};
               6'h22:   res_v = {1'b1, OP_SUB, rt};
               6'h24:   res_v = {1'b1, OP_AND, rt};
               6'h25:   res_v = {1'b1, OP_OR,  rt};
               6'h2A:   res_v = {1'b1, OP_SLT, rt};
               default: res_v = {1'b0, OP_AND, {WIDTH{1'b0}}};
            endcase
         end
         6'h08:   res_v = {1'b1, OP_ADD, sext_v};
         6'h0A:   res_v = {1'b1, OP_SLT, sext_v};
         6'h0C:   res_v = {1'b1, OP_AND, zext_v};
         6'h0D:   res_v = {1'b1, OP_OR,  zext_v};
         6'h23:   res_v = {1'b1, OP_ADD, sext_v};
         6'h2B:   res_v = {1'b1, OP_ADD, sext_v};
         6'h04:   res_v = {1'b1, OP_SUB, rt};
         default: res_v = {1'b0, OP_AND, {WIDTH{1'b0}}};
      endcase
      return res_v;
   endfunction

   always_comb begin
      dec_s       = decode_f(opcode_r, funct_r, rt_r, imm_r);
      dec_legal_s = dec_s[DEC_W-1];
      dec_op_s    = dec_s[DEC_W-2 -: 3];
      dec_b_s     = dec_s[WIDTH-1:0];
   end

   // Issue FSM; ALU operands are only rewritten in DECODE so they stay frozen through EXEC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         opcode_r    <= 6'h00;
         funct_r     <= 6'h00;
         rs_r        <= {WIDTH{1'b0}};
         rt_r        <= {WIDTH{1'b0}};
         imm_r       <= {IMM_W{1'b0}};
         alu_a_r     <= {WIDTH{1'b0}};
         alu_b_r     <= {WIDTH{1'b0}};
         alu_op_r    <= OP_AND;
         res_valid_r <= 1'b0;
         res_data_r  <= {WIDTH{1'b0}};
         res_taken_r <= 1'b0;
         res_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  opcode_r   <= bus.in_opcode;
                  funct_r    <= bus.in_funct;
                  rs_r       <= bus.in_rs;
                  rt_r       <= bus.in_rt;
                  imm_r      <= bus.in_imm;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_DECODE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_DECODE: begin
               if (dec_legal_s) begin
                  alu_a_r  <= rs_r;
                  alu_b_r  <= dec_b_s;
                  alu_op_r <= dec_op_s;
                  state_r  <= ST_EXEC;
               end else begin
                  res_data_r  <= ILLEGAL_VAL;
                  res_taken_r <= 1'b0;
                  res_err_r   <= 1'b1;
                  res_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end
            end
            ST_EXEC: begin
               res_data_r  <= bus.alu_z;
               res_taken_r <= (opcode_r == 6'h04) & bus.alu_ex;
               res_err_r   <= 1'b0;
               res_valid_r <= 1'b1;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.res_ready) begin
                  res_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               res_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.alu_a     = alu_a_r;
   assign bus.alu_b     = alu_b_r;
   assign bus.alu_op    = alu_op_r;
   assign bus.res_valid = res_valid_r;
   assign bus.res_data  = res_data_r;
   assign bus.res_taken = res_taken_r;
   assign bus.res_err   = res_err_r;

endmodule
